// File: rtl/dbg_gpr_access.sv
// dbg_gpr_access
//   Debug-side sequencer for the GPR file's debug port. It accepts one
//   valid/ready read or write request at a time and turns it into a
//   single-cycle register-file access. It then returns a response.
//   The execute stage owns the GPR write port whenever it writes a nonzero
//   register. Debug writes are therefore only issued in conflict-free cycles.
//   A write that stays blocked for TimeoutCyc cycles is abandoned and answered
//   with rsp_err_o=1.
// Ports
//   clk_i, rst_i                   clock, async active-high reset
//   req_valid_i/req_ready_o        request handshake
//   req_write_i/addr_i/wdata_i     request payload (1 = write)
//   rsp_valid_o/rsp_ready_i        response handshake
//   rsp_rdata_o, rsp_err_o         read data (0 for writes), write timeout
//   ex_we_i, ex_waddr_i            execute-stage write (priority writer)
//   gpr_we_o/addr_o/wdata_o        GPR debug port drive
//   gpr_rdata_i                    GPR debug read data (combinational)
module dbg_gpr_access #(
  parameter int AddrW      = 5,
  parameter int DataW      = 32,
  parameter int TimeoutCyc = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [AddrW-1:0] req_addr_i,
  input  logic [DataW-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DataW-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  input  logic             ex_we_i,
  input  logic [AddrW-1:0] ex_waddr_i,
  output logic             gpr_we_o,
  output logic [AddrW-1:0] gpr_addr_o,
  output logic [DataW-1:0] gpr_wdata_o,
  input  logic [DataW-1:0] gpr_rdata_i
);

  localparam int CntW = $clog2(TimeoutCyc + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCyc - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q,  addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [DataW-1:0] rdata_q, rdata_d;
  logic             err_q,   err_d;
  logic [CntW-1:0]  cnt_q,   cnt_d;
  logic             blocked;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writes to x0 by the execute stage are discarded by the GPR file, so they
  // do not occupy the write port.
  assign blocked = ex_we_i && (ex_waddr_i != '0);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    gpr_we_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = req_write_i ? WR : RD;
        end
      end
      RD: begin
        rdata_d = gpr_rdata_i;
        state_d = RESP;
      end
      WR: begin
        if (!blocked) begin
          // x0 completes as a no-op: the response is sent, but no strobe.
          gpr_we_o = (addr_q != '0);
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign gpr_addr_o  = addr_q;
  assign gpr_wdata_o = wdata_q;

endmodule

// File: tb/tb_dbg_gpr_access.sv
module tb_dbg_gpr_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic        gpr_we;
  logic [4:0]  gpr_addr;
  logic [31:0] gpr_wdata, gpr_rdata;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;

  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  dbg_gpr_access dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr),
    .gpr_we_o(gpr_we), .gpr_addr_o(gpr_addr), .gpr_wdata_o(gpr_wdata),
    .gpr_rdata_i(gpr_rdata)
  );

  // GPR file model: x0 reads 0; the execute stage writes a tag value and wins.
  initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (gpr_we) mem[gpr_addr] <= gpr_wdata;
    if (ex_we && ex_waddr != 5'd0) mem[ex_waddr] <= 32'hEEEE_0000 | {27'd0, ex_waddr};
  end
  assign gpr_rdata = (gpr_addr == 5'd0) ? 32'h0 : mem[gpr_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected response per response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
    if (gpr_we) we_cnt++;
    if (gpr_we && ex_we && ex_waddr != 5'd0) check("we_conflict", 32'd1, 32'd0);
  end

  // Returns just after the accepting edge (cycle N+1 begins).
  task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d);
    bit ok = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int n = 0; n < 50; n++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [31:0] r, input logic e);
    exp_t x;
    x.rdata = r; x.err = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    push(exp, 1'b0);
    issue(1'b0, a, 32'h0);
    drain();
  endtask

  initial begin
    int base;
    int lat;
    rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 1'b1; ex_we = 0; ex_waddr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_gpr_we", {31'd0, gpr_we}, 32'd0);
    check("rst_gpr_addr", {27'd0, gpr_addr}, 32'd0);
    check("rst_gpr_wdata", gpr_wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: plain write then readback, latency N+1 strobe / N+2 response
    base = we_cnt;
    push(32'h0, 1'b0);
    issue(1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_we_n1", {31'd0, gpr_we}, 32'd1);
    check("t1_addr_n1", {27'd0, gpr_addr}, 32'd5);
    check("t1_rsp_n1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("t1_rsp_n2", {31'd0, rsp_valid}, 32'd1);
    check("t1_we_n2", {31'd0, gpr_we}, 32'd0);
    drain();
    check("t1_we_pulses", we_cnt - base, 32'd1);
    rd(5'd5, 32'hDEADBEEF);

    // 2: blocked for 4 cycles by ex write to x3, fires on the 5th
    ex_we = 1'b1; ex_waddr = 5'd3;
    base = we_cnt;
    push(32'h0, 1'b0);
    issue(1'b1, 5'd7, 32'h0000_0077);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_we_blocked", {31'd0, gpr_we}, 32'd0);
    end
    @(posedge clk); #1;
    ex_we = 1'b0;
    @(negedge clk);
    check("t2_we_fire", {31'd0, gpr_we}, 32'd1);
    drain();
    check("t2_we_pulses", we_cnt - base, 32'd1);
    rd(5'd7, 32'h0000_0077);
    rd(5'd3, 32'hEEEE_0003);

    // 3: persistent block by ex write to x1 -> timeout after 16 blocked cycles
    ex_we = 1'b1; ex_waddr = 5'd1;
    base = we_cnt;
    push(32'h0, 1'b1);
    issue(1'b1, 5'd7, 32'h0000_0BAD);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check("t3_timeout_latency", lat, 32'd17);
    drain();
    @(posedge clk); #1;
    ex_we = 1'b0;
    check("t3_no_we", we_cnt - base, 32'd0);
    rd(5'd7, 32'h0000_0077);

    // 4: write to x0 is a no-op with a clean response
    base = we_cnt;
    push(32'h0, 1'b0);
    issue(1'b1, 5'd0, 32'h0000_1234);
    drain();
    check("t4_no_we", we_cnt - base, 32'd0);
    rd(5'd0, 32'h0);

    // 5: response backpressure holds outputs and blocks new requests
    base = we_cnt;
    rsp_ready = 1'b0;
    push(32'hDEADBEEF, 1'b0);
    issue(1'b0, 5'd5, 32'h0);
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd9; req_wdata = 32'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("t5_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("t5_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();
    check("t5_no_we", we_cnt - base, 32'd0);
    rd(5'd9, 32'h0);

    // 6: reset during WR drops the strobe immediately, no response
    issue(1'b1, 5'd10, 32'h0000_AAAA);
    check("t6_we_before", {31'd0, gpr_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_we_reset", {31'd0, gpr_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_req_ready", {31'd0, req_ready}, 32'd1);
    check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rd(5'd10, 32'h0);

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
